// File: rtl/intersection_sched_pkg.sv
// Shared phase encodings, lamp/display constants and small arithmetic helpers
// for the intersection phase scheduler.
package intersection_sched_pkg;

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    CLR1   = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    CLR2   = 3'd5,
    EMG    = 3'd6,
    TEST   = 3'd7
  } phase_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;
  localparam logic [2:0] ALL = 3'b111;

  localparam logic [7:0] BLANK = 8'h88;

  localparam logic [1:0] CFG_G_MAIN = 2'd0;
  localparam logic [1:0] CFG_G_SIDE = 2'd1;
  localparam logic [1:0] CFG_YEL    = 2'd2;
  localparam logic [1:0] CFG_CLR    = 2'd3;

  typedef struct packed {
    logic [7:0] g_main;
    logic [7:0] g_side;
    logic [7:0] yel;
    logic [7:0] clr;
  } cfg_t;

  // Green and yellow never run for zero seconds; a zero setting means one.
  function automatic logic [7:0] min_one(input logic [7:0] d);
    return (d == 8'd0) ? 8'd1 : d;
  endfunction

  function automatic logic [9:0] widen(input logic [7:0] v);
    return {2'b00, v};
  endfunction

  function automatic logic [7:0] sat99(input logic [9:0] v);
    return (v > 10'd99) ? 8'd99 : v[7:0];
  endfunction

  // Normal rotation order; EMG/TEST never reach here.
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      MAIN_G:  return MAIN_Y;
      MAIN_Y:  return CLR1;
      CLR1:    return SIDE_G;
      SIDE_G:  return SIDE_Y;
      SIDE_Y:  return CLR2;
      CLR2:    return MAIN_G;
      default: return CLR2;
    endcase
  endfunction

endpackage

// File: rtl/intersection_sched_phase_timer.sv
// Per-phase seconds counter: loaded on phase entry, counts down on each tick,
// holds at zero, and flags the tick that ends a phase.
module intersection_sched_phase_timer #(
  parameter logic [7:0] RST_VAL = 8'd30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] dur,
  input  logic       tick,
  output logic [7:0] rem,
  output logic       expire
);

  // Load has priority over counting so a phase entry on a tick starts fresh.
  always_ff @(posedge clk) begin
    if (rst)
      rem <= RST_VAL;
    else if (load)
      rem <= dur;
    else if (tick && (rem != 8'd0))
      rem <= rem - 8'd1;
  end

  assign expire = tick && (rem == 8'd1);

endmodule

// File: rtl/intersection_sched.sv
// Two-approach intersection scheduler: phase FSM, side-demand latch,
// shadow/active timing configuration and countdown display generation.
module intersection_sched
  import intersection_sched_pkg::*;
#(
  parameter logic [7:0] DEF_G_MAIN = 8'd30,
  parameter logic [7:0] DEF_G_SIDE = 8'd20,
  parameter logic [7:0] DEF_YEL    = 8'd3,
  parameter logic [7:0] DEF_CLR    = 8'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       side_req,
  input  logic       emergency,
  input  logic       test,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_data,
  output logic [2:0] main_ryg,
  output logic [2:0] side_ryg,
  output logic [7:0] main_wait,
  output logic [7:0] side_wait,
  output logic [2:0] phase
);

  localparam cfg_t CFG_DEF = '{g_main: DEF_G_MAIN, g_side: DEF_G_SIDE,
                               yel: DEF_YEL, clr: DEF_CLR};

  phase_t     phase_q, phase_nxt, target;
  logic       flash, flash_nxt;
  logic       req_pend;
  cfg_t       shadow, active;
  logic       tmr_load, tmr_expire, advance;
  logic [7:0] tmr_dur, rem;
  logic       enter_main_g, enter_side_g;

  intersection_sched_phase_timer #(
    .RST_VAL(DEF_G_MAIN)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .dur    (tmr_dur),
    .tick   (tick),
    .rem    (rem),
    .expire (tmr_expire)
  );

  // Next-phase selection with emergency > test > normal priority and CLR skip.
  always_comb begin
    phase_nxt = phase_q;
    target    = MAIN_G;
    advance   = 1'b0;
    tmr_load  = 1'b0;
    tmr_dur   = '0;
    flash_nxt = 1'b0;
    if (emergency) begin
      phase_nxt = EMG;
      tmr_load  = 1'b1;
    end else if (test) begin
      phase_nxt = TEST;
      tmr_load  = 1'b1;
      flash_nxt = (phase_q == TEST) ? (flash ^ tick) : 1'b0;
    end else begin
      case (phase_q)
        EMG, TEST: begin
          advance = 1'b1;
          target  = CLR2;
        end
        MAIN_G: begin
          // Leaves on the expiry tick if demand is waiting, else rests at zero.
          advance = req_pend && (tmr_expire || (tick && (rem == 8'd0)));
          target  = MAIN_Y;
        end
        default: begin
          advance = tmr_expire;
          target  = next_phase(phase_q);
        end
      endcase
      if (advance) begin
        // A zero clearance setting passes straight through to the following phase.
        if (((target == CLR1) || (target == CLR2)) && (active.clr == 8'd0))
          target = next_phase(target);
        phase_nxt = target;
        tmr_load  = 1'b1;
        case (target)
          MAIN_G:     tmr_dur = min_one(shadow.g_main);
          MAIN_Y:     tmr_dur = min_one(active.yel);
          SIDE_G:     tmr_dur = min_one(active.g_side);
          SIDE_Y:     tmr_dur = min_one(active.yel);
          CLR1, CLR2: tmr_dur = active.clr;
          default:    tmr_dur = '0;
        endcase
      end
    end
  end

  assign enter_main_g = (phase_nxt == MAIN_G) && (phase_q != MAIN_G);
  assign enter_side_g = (phase_nxt == SIDE_G) && (phase_q != SIDE_G);

  // Phase and lamp-test flash registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= MAIN_G;
      flash   <= 1'b0;
    end else begin
      phase_q <= phase_nxt;
      flash   <= flash_nxt;
    end
  end

  // Side demand latch; a request coincident with SIDE_G entry survives.
  always_ff @(posedge clk) begin
    if (rst)
      req_pend <= 1'b0;
    else
      req_pend <= side_req | (req_pend & ~enter_side_g);
  end

  // Shadow takes writes at once; active follows only at the start of main green.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= CFG_DEF;
      active <= CFG_DEF;
    end else begin
      if (cfg_we) begin
        case (cfg_addr)
          CFG_G_MAIN: shadow.g_main <= cfg_data;
          CFG_G_SIDE: shadow.g_side <= cfg_data;
          CFG_YEL:    shadow.yel    <= cfg_data;
          default:    shadow.clr    <= cfg_data;
        endcase
      end
      if (enter_main_g)
        active <= shadow;
    end
  end

  // Lamp decode from registered phase.
  always_comb begin
    main_ryg = RED;
    side_ryg = RED;
    case (phase_q)
      MAIN_G: main_ryg = GRN;
      MAIN_Y: main_ryg = YEL;
      SIDE_G: side_ryg = GRN;
      SIDE_Y: side_ryg = YEL;
      TEST: begin
        main_ryg = flash ? ALL : OFF;
        side_ryg = flash ? ALL : OFF;
      end
      default: ;
    endcase
  end

  // Countdown displays: red approach sums the phases still ahead of its green.
  always_comb begin
    main_wait = BLANK;
    side_wait = BLANK;
    case (phase_q)
      MAIN_G: begin
        main_wait = rem;
        if ((rem != 8'd0) && req_pend)
          side_wait = sat99(widen(rem) + widen(min_one(active.yel)) + widen(active.clr));
      end
      MAIN_Y: begin
        main_wait = rem;
        side_wait = sat99(widen(rem) + widen(active.clr));
      end
      CLR1: begin
        main_wait = sat99(widen(rem) + widen(min_one(active.g_side)) +
                          widen(min_one(active.yel)) + widen(active.clr));
        side_wait = rem;
      end
      SIDE_G: begin
        main_wait = sat99(widen(rem) + widen(min_one(active.yel)) + widen(active.clr));
        side_wait = rem;
      end
      SIDE_Y: begin
        main_wait = sat99(widen(rem) + widen(active.clr));
        side_wait = rem;
      end
      CLR2: begin
        // Timing after the next main green comes from the shadow set it will adopt.
        main_wait = rem;
        if (req_pend)
          side_wait = sat99(widen(rem) + widen(min_one(shadow.g_main)) +
                            widen(min_one(shadow.yel)) + widen(shadow.clr));
      end
      default: ;
    endcase
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_intersection_sched.sv
// Directed bench for intersection_sched with hand-computed expectations.
module tb_intersection_sched;

  localparam logic [2:0] P_MAIN_G = 3'd0, P_MAIN_Y = 3'd1, P_CLR1 = 3'd2,
                         P_SIDE_G = 3'd3, P_SIDE_Y = 3'd4, P_CLR2 = 3'd5,
                         P_EMG = 3'd6, P_TEST = 3'd7;
  localparam logic [2:0] L_R = 3'b100, L_Y = 3'b010, L_G = 3'b001,
                         L_OFF = 3'b000, L_ALL = 3'b111;
  localparam logic [7:0] BL = 8'h88;

  logic       clk = 1'b0;
  logic       rst, tick, side_req, emergency, test, cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;
  logic [2:0] main_ryg, side_ryg, phase;
  logic [7:0] main_wait, side_wait;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  intersection_sched dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .side_req  (side_req),
    .emergency (emergency),
    .test      (test),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .main_ryg  (main_ryg),
    .side_ryg  (side_ryg),
    .main_wait (main_wait),
    .side_wait (side_wait),
    .phase     (phase)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] ph, input logic [2:0] m,
                         input logic [2:0] s, input logic [7:0] mw, input logic [7:0] sw);
    chk({tag, ".phase"}, {5'd0, phase}, {5'd0, ph});
    chk({tag, ".main_ryg"}, {5'd0, main_ryg}, {5'd0, m});
    chk({tag, ".side_ryg"}, {5'd0, side_ryg}, {5'd0, s});
    chk({tag, ".main_wait"}, main_wait, mw);
    chk({tag, ".side_wait"}, side_wait, sw);
  endtask

  // One clock with the given tick/side_req values, sampled at the next falling edge.
  task automatic step(input logic t, input logic sr);
    tick = t;
    side_req = sr;
    @(negedge clk);
    tick = 1'b0;
    side_req = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    step(1'b0, 1'b0);
    cfg_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; side_req = 1'b0; emergency = 1'b0; test = 1'b0;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 8'd0;
    @(negedge clk);
    step(1'b0, 1'b0);
    rst = 1'b0;
    chk_all("reset", P_MAIN_G, L_G, L_R, 8'd30, BL);

    // No demand: main green counts to zero and rests.
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 1'b0);
      chk("idle.main_wait", main_wait, (i < 30) ? 8'(30 - i) : 8'd0);
      chk("idle.side_wait", side_wait, BL);
      chk("idle.phase", {5'd0, phase}, {5'd0, P_MAIN_G});
    end
    step(1'b0, 1'b1);
    chk_all("rest_req", P_MAIN_G, L_G, L_R, 8'd0, BL);
    step(1'b1, 1'b0);
    chk_all("rest_leave", P_MAIN_Y, L_Y, L_R, 8'd3, 8'd5);

    // Full cycle with a demand pulse at tick 10.
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
    chk_all("reset2", P_MAIN_G, L_G, L_R, 8'd30, BL);
    ticks(10);
    step(1'b0, 1'b1);
    chk_all("req10", P_MAIN_G, L_G, L_R, 8'd20, 8'd25);
    ticks(19);
    chk_all("t29", P_MAIN_G, L_G, L_R, 8'd1, 8'd6);
    ticks(1);
    chk_all("t30", P_MAIN_Y, L_Y, L_R, 8'd3, 8'd5);
    ticks(2);
    chk_all("t32", P_MAIN_Y, L_Y, L_R, 8'd1, 8'd3);
    ticks(1);
    chk_all("t33", P_CLR1, L_R, L_R, 8'd27, 8'd2);
    ticks(2);
    chk_all("t35", P_SIDE_G, L_R, L_G, 8'd25, 8'd20);
    cfg_write(2'd0, 8'd5);
    chk_all("cfgw", P_SIDE_G, L_R, L_G, 8'd25, 8'd20);
    ticks(19);
    chk_all("t54", P_SIDE_G, L_R, L_G, 8'd6, 8'd1);
    ticks(1);
    chk_all("t55", P_SIDE_Y, L_R, L_Y, 8'd5, 8'd3);
    ticks(3);
    chk_all("t58", P_CLR2, L_R, L_R, 8'd2, BL);
    ticks(2);
    chk_all("t60", P_MAIN_G, L_G, L_R, 8'd5, BL);
    ticks(4);
    chk_all("t64", P_MAIN_G, L_G, L_R, 8'd1, BL);
    ticks(1);
    chk_all("t65", P_MAIN_G, L_G, L_R, 8'd0, BL);

    // Emergency preemption in the middle of side green.
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    chk_all("f_my", P_MAIN_Y, L_Y, L_R, 8'd3, 8'd5);
    ticks(5);
    chk_all("f_sg", P_SIDE_G, L_R, L_G, 8'd25, 8'd20);
    ticks(5);
    emergency = 1'b1;
    step(1'b0, 1'b0);
    chk_all("emg", P_EMG, L_R, L_R, BL, BL);
    ticks(3);
    chk_all("emg_hold", P_EMG, L_R, L_R, BL, BL);
    emergency = 1'b0;
    step(1'b0, 1'b0);
    chk_all("emg_rel", P_CLR2, L_R, L_R, 8'd2, BL);
    ticks(2);
    chk_all("emg_main", P_MAIN_G, L_G, L_R, 8'd5, BL);

    // Lamp test flashing, overridden by emergency.
    test = 1'b1;
    step(1'b0, 1'b0);
    chk_all("test0", P_TEST, L_OFF, L_OFF, BL, BL);
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b0);
      chk("test.main_ryg", {5'd0, main_ryg}, {5'd0, (k % 2 == 1) ? L_ALL : L_OFF});
      chk("test.side_ryg", {5'd0, side_ryg}, {5'd0, (k % 2 == 1) ? L_ALL : L_OFF});
    end
    emergency = 1'b1;
    step(1'b0, 1'b0);
    chk_all("test_emg", P_EMG, L_R, L_R, BL, BL);
    emergency = 1'b0;
    step(1'b0, 1'b0);
    chk_all("test_back", P_TEST, L_OFF, L_OFF, BL, BL);
    test = 1'b0;
    step(1'b0, 1'b0);
    chk_all("test_rel", P_CLR2, L_R, L_R, 8'd2, BL);
    ticks(2);
    chk_all("test_main", P_MAIN_G, L_G, L_R, 8'd5, BL);

    // Demand already pending leaves on the expiry tick; reset in SIDE_Y.
    step(1'b0, 1'b1);
    chk_all("h_req", P_MAIN_G, L_G, L_R, 8'd5, 8'd10);
    ticks(5);
    chk_all("h_my", P_MAIN_Y, L_Y, L_R, 8'd3, 8'd5);
    ticks(25);
    chk_all("h_sy", P_SIDE_Y, L_R, L_Y, 8'd5, 8'd3);
    step(1'b0, 1'b1);
    rst = 1'b1;
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd9;
    step(1'b0, 1'b0);
    rst = 1'b0;
    cfg_we = 1'b0;
    chk_all("h_reset", P_MAIN_G, L_G, L_R, 8'd30, BL);

    // Zero clearance, adopted at the next main green entry.
    cfg_write(2'd3, 8'd0);
    emergency = 1'b1;
    step(1'b0, 1'b0);
    emergency = 1'b0;
    step(1'b0, 1'b0);
    chk_all("z_clr2", P_CLR2, L_R, L_R, 8'd2, BL);
    ticks(2);
    chk_all("z_main", P_MAIN_G, L_G, L_R, 8'd30, BL);
    step(1'b0, 1'b1);
    chk_all("z_req", P_MAIN_G, L_G, L_R, 8'd30, 8'd33);
    ticks(30);
    chk_all("z_my", P_MAIN_Y, L_Y, L_R, 8'd3, 8'd3);
    ticks(3);
    chk_all("z_sg", P_SIDE_G, L_R, L_G, 8'd23, 8'd20);
    ticks(20);
    chk_all("z_sy", P_SIDE_Y, L_R, L_Y, 8'd3, 8'd3);
    ticks(3);
    chk_all("z_mg", P_MAIN_G, L_G, L_R, 8'd30, BL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
